// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the GPIO pad controller.
package gpio_pad_pkg;

   localparam int unsigned GPIO_DS_W  = 4;
   localparam int unsigned GPIO_STE_W = 2;

   typedef struct packed {
      logic [GPIO_DS_W-1:0]  ds;
      logic                  sr;
      logic                  co;
      logic                  odp;
      logic                  odn;
      logic                  pu;
      logic                  pd;
      logic [GPIO_STE_W-1:0] ste;
   } gpio_cfg_t;

   localparam gpio_cfg_t GPIO_CFG_RST = '0;

endpackage

// File: rtl/gpio_in_filter.sv
// Pad receiver path: synchroniser, deglitch counter and filtered edge detection.
module gpio_in_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             d_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             q_o,
   output logic             rise_o,
   output logic             fall_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_inc;
   logic [CNT_W-1:0]       len_q;
   logic                   q_d;

   assign s       = sync[SYNC_STAGES-1];
   assign cnt_inc = cnt + CNT_W'(1);

   // The counter only runs while s disagrees with the filtered level and the length is stable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync   <= '0;
         cnt    <= '0;
         len_q  <= '0;
         q_o    <= 1'b0;
         q_d    <= 1'b0;
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], d_i};
         len_q  <= len_i;
         q_d    <= q_o;
         rise_o <= q_o & ~q_d;
         fall_o <= ~q_o & q_d;
         if (len_i == '0) begin
            q_o <= s;
            cnt <= '0;
         end else if ((len_i != len_q) || (s == q_o)) begin
            cnt <= '0;
         end else if (cnt_inc == len_i) begin
            q_o <= s;
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for one GPIO pad: registered pad controls, glitch-free OE, filtered input and irq.
module gpio_pad_ctrl
   import gpio_pad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  out_val_i,
   input  logic                  out_en_i,
   input  logic [GPIO_DS_W-1:0]  cfg_ds_i,
   input  logic                  cfg_sr_i,
   input  logic                  cfg_co_i,
   input  logic                  cfg_odp_i,
   input  logic                  cfg_odn_i,
   input  logic                  cfg_pu_i,
   input  logic                  cfg_pd_i,
   input  logic [GPIO_STE_W-1:0] cfg_ste_i,
   input  logic                  in_en_i,
   input  logic [CNT_W-1:0]      filt_len_i,
   input  logic                  irq_rise_i,
   input  logic                  irq_fall_i,
   input  logic                  irq_clr_i,
   output logic                  pad_do_o,
   output logic                  pad_oe_o,
   output logic                  pad_sr_o,
   output logic                  pad_co_o,
   output logic                  pad_odp_o,
   output logic                  pad_odn_o,
   output logic                  pad_ie_o,
   output logic                  pad_pu_o,
   output logic                  pad_pd_o,
   output logic [GPIO_DS_W-1:0]  pad_ds_o,
   output logic [GPIO_STE_W-1:0] pad_ste_o,
   input  logic [1:0]            pad_di_i,
   output logic                  in_val_o,
   output logic                  rise_o,
   output logic                  fall_o,
   output logic                  irq_o
);

   gpio_cfg_t cfg_in;
   gpio_cfg_t cfg_q;
   logic      en_q;
   logic      di_unused;

   assign di_unused = pad_di_i[1];

   assign cfg_in = '{ds: cfg_ds_i, sr: cfg_sr_i, co: cfg_co_i, odp: cfg_odp_i,
                     odn: cfg_odn_i, pu: cfg_pu_i, pd: cfg_pd_i, ste: cfg_ste_i};

   // OE turns on one cycle after data is loaded; a lone request still yields one OE cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q    <= GPIO_CFG_RST;
         pad_do_o <= 1'b0;
         pad_oe_o <= 1'b0;
         pad_ie_o <= 1'b0;
         en_q     <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         cfg_q    <= cfg_in;
         pad_ie_o <= in_en_i;
         en_q     <= out_en_i;
         pad_oe_o <= en_q & (out_en_i | ~pad_oe_o);
         if (out_en_i) begin
            pad_do_o <= out_val_i;
         end
         if ((rise_o & irq_rise_i) | (fall_o & irq_fall_i)) begin
            irq_o <= 1'b1;
         end else if (irq_clr_i) begin
            irq_o <= 1'b0;
         end
      end
   end

   assign pad_ds_o  = cfg_q.ds;
   assign pad_sr_o  = cfg_q.sr;
   assign pad_co_o  = cfg_q.co;
   assign pad_odp_o = cfg_q.odp;
   assign pad_odn_o = cfg_q.odn;
   assign pad_pu_o  = cfg_q.pu;
   assign pad_pd_o  = cfg_q.pd;
   assign pad_ste_o = cfg_q.ste;

   gpio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) u_in_filter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (pad_di_i[0]),
      .len_i  (filt_len_i),
      .q_o    (in_val_o),
      .rise_o (rise_o),
      .fall_o (fall_o)
   );

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: history-based reference model plus directed scenario checks.
module tb_gpio_pad_ctrl;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned CNT_W       = 8;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             out_val_i, out_en_i;
   logic [3:0]       cfg_ds_i;
   logic             cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_pu_i, cfg_pd_i;
   logic [1:0]       cfg_ste_i;
   logic             in_en_i;
   logic [CNT_W-1:0] filt_len_i;
   logic             irq_rise_i, irq_fall_i, irq_clr_i;
   logic [1:0]       pad_di_i;
   logic             pad_do_o, pad_oe_o, pad_sr_o, pad_co_o, pad_odp_o, pad_odn_o;
   logic             pad_ie_o, pad_pu_o, pad_pd_o;
   logic [3:0]       pad_ds_o;
   logic [1:0]       pad_ste_o;
   logic             in_val_o, rise_o, fall_o, irq_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   gpio_pad_ctrl #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .out_val_i(out_val_i), .out_en_i(out_en_i),
      .cfg_ds_i(cfg_ds_i), .cfg_sr_i(cfg_sr_i), .cfg_co_i(cfg_co_i), .cfg_odp_i(cfg_odp_i),
      .cfg_odn_i(cfg_odn_i), .cfg_pu_i(cfg_pu_i), .cfg_pd_i(cfg_pd_i), .cfg_ste_i(cfg_ste_i),
      .in_en_i(in_en_i), .filt_len_i(filt_len_i), .irq_rise_i(irq_rise_i),
      .irq_fall_i(irq_fall_i), .irq_clr_i(irq_clr_i),
      .pad_do_o(pad_do_o), .pad_oe_o(pad_oe_o), .pad_sr_o(pad_sr_o), .pad_co_o(pad_co_o),
      .pad_odp_o(pad_odp_o), .pad_odn_o(pad_odn_o), .pad_ie_o(pad_ie_o), .pad_pu_o(pad_pu_o),
      .pad_pd_o(pad_pd_o), .pad_ds_o(pad_ds_o), .pad_ste_o(pad_ste_o), .pad_di_i(pad_di_i),
      .in_val_o(in_val_o), .rise_o(rise_o), .fall_o(fall_o), .irq_o(irq_o)
   );

   logic [18:0] got;
   assign got = {pad_do_o, pad_oe_o, pad_sr_o, pad_co_o, pad_odp_o, pad_odn_o, pad_ie_o,
                 pad_pu_o, pad_pd_o, pad_ds_o, pad_ste_o, in_val_o, rise_o, fall_o, irq_o};

   // Reference model state: values expected on the outputs after the latest clock edge.
   logic        m_do, m_oe, m_sr, m_co, m_odp, m_odn, m_ie, m_pu, m_pd;
   logic [3:0]  m_ds;
   logic [1:0]  m_ste;
   logic        m_q, m_q_old, m_rise, m_fall, m_irq;
   logic        en_h1, en_h2;
   logic [7:0]  len_prev;
   logic        d_hist[$];
   logic        s_hist[$];
   logic [18:0] sb[$];

   task automatic model_proc();
      logic       s, nq, all_eq;
      logic [7:0] len;
      forever begin
         @(posedge clk_i);
         if (rst_i) begin
            {m_do, m_oe, m_sr, m_co, m_odp, m_odn, m_ie, m_pu, m_pd} = '0;
            m_ds = '0; m_ste = '0;
            {m_q, m_q_old, m_rise, m_fall, m_irq} = '0;
            en_h1 = 1'b0; en_h2 = 1'b0; len_prev = '0;
            d_hist.delete();
            for (int i = 0; i < int'(SYNC_STAGES); i++) d_hist.push_back(1'b0);
            s_hist.delete();
         end else begin
            s = d_hist[SYNC_STAGES-1];
            d_hist.push_front(pad_di_i[0]);
            void'(d_hist.pop_back());
            if ((m_rise && irq_rise_i) || (m_fall && irq_fall_i)) m_irq = 1'b1;
            else if (irq_clr_i) m_irq = 1'b0;
            m_rise  = m_q && !m_q_old;
            m_fall  = !m_q && m_q_old;
            m_q_old = m_q;
            // Filtered level follows s once s has held a new value for len consecutive samples.
            len = filt_len_i;
            nq  = m_q;
            if (len == 0) begin
               nq = s;
               s_hist.delete();
            end else if (len != len_prev) begin
               s_hist.delete();
            end else begin
               s_hist.push_front(s);
               if (s_hist.size() > 300) void'(s_hist.pop_back());
               if (s_hist.size() >= int'(len)) begin
                  all_eq = 1'b1;
                  for (int i = 0; i < int'(len); i++) if (s_hist[i] != s) all_eq = 1'b0;
                  if (all_eq && (s != m_q)) begin
                     nq = s;
                     s_hist.delete();
                  end
               end
            end
            m_q = nq;
            len_prev = len;
            // OE: on while request held for 2 samples, or for one cycle after an isolated 1-sample request.
            m_oe  = (out_en_i && en_h1) || (!out_en_i && en_h1 && !en_h2);
            en_h2 = en_h1;
            en_h1 = out_en_i;
            if (out_en_i) m_do = out_val_i;
            m_sr = cfg_sr_i; m_co = cfg_co_i; m_odp = cfg_odp_i; m_odn = cfg_odn_i;
            m_pu = cfg_pu_i; m_pd = cfg_pd_i; m_ds = cfg_ds_i; m_ste = cfg_ste_i;
            m_ie = in_en_i;
         end
         sb.push_back({m_do, m_oe, m_sr, m_co, m_odp, m_odn, m_ie, m_pu, m_pd, m_ds, m_ste,
                       m_q, m_rise, m_fall, m_irq});
      end
   endtask

   task automatic monitor_proc();
      logic [18:0] exp_v;
      forever begin
         @(negedge clk_i);
         if (sb.size() != 0) begin
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL outputs @%0t: got %05h expected %05h", $time, got, exp_v);
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_inval(input logic v, input int limit, output int n);
      n = 0;
      while ((in_val_o !== v) && (n < limit)) begin
         tick();
         n++;
      end
   endtask

   task automatic set_pad(input logic v);
      pad_di_i = {1'($urandom), v};
   endtask

   initial begin
      int  n;
      int  run;
      logic seen, pbit;
      fork
         model_proc();
         monitor_proc();
      join_none

      // Reset with every input high
      {out_val_i, out_en_i, cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_pu_i, cfg_pd_i} = '1;
      cfg_ds_i = '1; cfg_ste_i = '1; in_en_i = 1'b1; filt_len_i = '1;
      {irq_rise_i, irq_fall_i, irq_clr_i} = '1; pad_di_i = 2'b11;
      rst_i = 1'b1;
      tick(); tick();
      chk("reset_outputs", 32'(got), 32'd0);

      {out_val_i, out_en_i, cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_pu_i, cfg_pd_i} = '0;
      cfg_ds_i = 4'h5; cfg_ste_i = 2'b10; filt_len_i = 8'd4;
      {irq_rise_i, irq_fall_i, irq_clr_i} = '0; set_pad(1'b0);
      rst_i = 1'b0;
      repeat (10) tick();
      chk("cfg_ds", 32'(pad_ds_o), 32'h5);

      // OE sequencing
      out_val_i = 1'b1; out_en_i = 1'b1;
      tick();
      chk("oe_rise_do", 32'(pad_do_o), 32'd1);
      chk("oe_rise_oe_n1", 32'(pad_oe_o), 32'd0);
      tick();
      chk("oe_rise_oe_n2", 32'(pad_oe_o), 32'd1);
      repeat (8) tick();
      out_en_i = 1'b0; out_val_i = 1'b0;
      tick();
      chk("oe_fall_oe", 32'(pad_oe_o), 32'd0);
      chk("oe_fall_do", 32'(pad_do_o), 32'd1);
      repeat (3) tick();
      out_en_i = 1'b1;
      tick();
      out_en_i = 1'b0;
      chk("oe_pulse_n1", 32'(pad_oe_o), 32'd0);
      tick();
      chk("oe_pulse_n2", 32'(pad_oe_o), 32'd1);
      tick();
      chk("oe_pulse_n3", 32'(pad_oe_o), 32'd0);

      // Deglitch, length 4
      set_pad(1'b1);
      repeat (3) tick();
      set_pad(1'b0);
      seen = 1'b0;
      repeat (12) begin
         tick();
         seen = seen | in_val_o | rise_o;
      end
      chk("short_pulse_blocked", 32'(seen), 32'd0);
      set_pad(1'b1);
      wait_inval(1'b1, 20, n);
      chk("latency_len4", 32'(n), 32'd6);
      tick();
      chk("rise_after_inval", 32'(rise_o), 32'd1);
      repeat (3) tick();
      set_pad(1'b0);
      wait_inval(1'b0, 20, n);
      chk("fall_latency_len4", 32'(n), 32'd6);

      // Bypass, length 0
      filt_len_i = 8'd0;
      repeat (5) tick();
      set_pad(1'b1);
      wait_inval(1'b1, 20, n);
      chk("latency_len0_rise", 32'(n), 32'(SYNC_STAGES + 1));
      set_pad(1'b0);
      wait_inval(1'b0, 20, n);
      chk("latency_len0_fall", 32'(n), 32'(SYNC_STAGES + 1));

      // Interrupt behaviour
      irq_rise_i = 1'b1; irq_fall_i = 1'b0;
      repeat (4) tick();
      set_pad(1'b1);
      wait_inval(1'b1, 20, n);
      tick();
      tick();
      chk("irq_set_on_rise", 32'(irq_o), 32'd1);
      set_pad(1'b0);
      repeat (8) tick();
      chk("irq_kept_on_fall", 32'(irq_o), 32'd1);
      set_pad(1'b1);
      wait_inval(1'b1, 20, n);
      tick();
      chk("rise_pulse", 32'(rise_o), 32'd1);
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      chk("irq_set_beats_clr", 32'(irq_o), 32'd1);
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      chk("irq_lone_clr", 32'(irq_o), 32'd0);

      // Reset in the middle of a count
      filt_len_i = 8'd4;
      set_pad(1'b0);
      repeat (10) tick();
      set_pad(1'b1);
      repeat (4) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midcount_rst_inval", 32'(in_val_o), 32'd0);
      chk("midcount_rst_irq", 32'(irq_o), 32'd0);
      wait_inval(1'b1, 20, n);
      chk("restart_latency", 32'(n), 32'd6);

      // Randomised traffic
      pbit = 1'b1;
      run  = 0;
      for (int c = 0; c < 3000; c++) begin
         if ((c % 250) == 0) begin
            case ($urandom_range(0, 4))
               0: filt_len_i = 8'd0;
               1: filt_len_i = 8'd1;
               2: filt_len_i = 8'd2;
               3: filt_len_i = 8'd4;
               default: filt_len_i = 8'd7;
            endcase
            irq_rise_i = 1'($urandom);
            irq_fall_i = 1'($urandom);
         end
         if (run == 0) begin
            pbit = ~pbit;
            run  = int'($urandom_range(1, 9));
         end
         run--;
         set_pad(pbit);
         out_val_i = 1'($urandom);
         if ($urandom_range(0, 3) == 0) out_en_i = ~out_en_i;
         if ($urandom_range(0, 31) == 0) in_en_i = ~in_en_i;
         {cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_pu_i, cfg_pd_i} = 6'($urandom);
         cfg_ds_i   = 4'($urandom);
         cfg_ste_i  = 2'($urandom);
         irq_clr_i  = ($urandom_range(0, 7) == 0);
         rst_i      = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst_i = 1'b0;
      irq_clr_i = 1'b0;
      repeat (3) tick();
      @(negedge clk_i);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
